psr_unit: RTL
=============

// Module: psr_unit
// PURPOSE
//  Processor Status Register unit: condition codes (NZP), privilege bit and priority field.
//  Parametrised successor of the single NZP register; adds the branch-enable (BEN) latch.
//  Adds a LIFO shadow stack that saves the PSR on interrupt entry and restores it on RTI.
//  Sits beside the data path: reads the bus; drives the control store (NZP, BEN) and the bus (PSR).
// PARAMETERS
//  DATA_W       16  bus/PSR width; privilege bit is PSR[DATA_W-1]; legal range 12..32
//  PRI_W        3   priority field width, located at PSR[PRI_LSB +: PRI_W]
//  STACK_DEPTH  4   shadow-stack entries (>=1)
// PORTS
//  i_CLK          in   1            clock, all state updates on posedge
//  i_RST          in   1            synchronous reset, active-high
//  i_LD_CC        in   1            update NZP from i_Bus
//  i_Bus          in   DATA_W       data-path bus value
//  i_LD_PSR       in   1            load whole PSR from i_Bus (priv, pri, NZP fields)
//  i_LD_BEN       in   1            latch branch-enable
//  i_IR_NZP       in   3            IR[11:9] branch mask {n,z,p}
//  i_Push         in   1            interrupt entry: save PSR, enter supervisor at i_Int_Pri
//  i_Int_Pri      in   PRI_W        priority of accepted interrupt
//  i_Pop          in   1            RTI: restore PSR from stack top
//  o_NZP          out  3            {N,Z,P}; Z is bit 1
//  o_PSR          out  DATA_W       {priv, 0.., pri, 0.., N,Z,P}; unused bits read 0
//  o_Priv         out  1            1 = user, 0 = supervisor
//  o_Pri          out  PRI_W        current priority
//  o_BEN          out  1            registered branch enable
//  o_Stack_Empty  out  1            stack count == 0
//  o_Stack_Full   out  1            stack count == STACK_DEPTH
//  o_Err          out  1            sticky stack error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, highest priority): NZP=3'b010, priv=0, pri=0, BEN=0, count=0, o_Err=0; stack contents don't-care.
//  - CC logic: N=i_Bus[DATA_W-1]; Z=(i_Bus==0); P=!N&&!Z. Exactly one bit set.
//  - All outputs are registered; an update is visible 1 cycle after the load strobe.
//  - Per-cycle priority after reset: i_Pop > i_Push > i_LD_PSR > i_LD_CC. Lower-priority PSR strobes in the same cycle are dropped.
//  - i_LD_BEN is independent of the PSR strobes: BEN <= |(i_IR_NZP & NZP) using the pre-update NZP.
//  - Push (count<FULL): stack[count] <= current PSR; count++; priv<=0; pri<=i_Int_Pri; NZP<=3'b010.
//  - Push when full: no state change; error event.
//  - Pop (count>0): count--; PSR <= stack[count-1] (all fields).
//  - Pop when empty: no state change; error event.
//  - Push and Pop in the same cycle: Pop executes, Push is dropped; error event.
//  - i_LD_PSR: priv<=i_Bus[DATA_W-1]; pri<=i_Bus[PRI_LSB+:PRI_W]; NZP<=i_Bus[2:0] raw (no one-hot check).
//  - Reset asserted mid-sequence overrides every strobe in that cycle.
// CONFIGURATION
//  PSR_STACK_ERR_EN defined: any error event sets o_Err, held until i_RST.
//  PSR_STACK_ERR_EN undefined: o_Err tied 0; error events are silently ignored; stack behaviour is otherwise identical.
// STRUCTURE
//  lc3_pkg: PRI_LSB=8, NZP_RESET=3'b010, PRIV_USER=1'b1, PRIV_SUPER=1'b0, NZP bit indices.
//  Sub-module psr_lifo (WIDTH, DEPTH): push/pop, count, full/empty flags, top-of-stack read.
//  Top level holds the PSR registers, CC logic, BEN latch, priority mux and the error flag.
// TESTING
//  1 Reset, then i_LD_CC with Bus=16'h8000 / 16'h0000 / 16'h0001 -> NZP 100 / 010 / 001, each one cycle later.
//  2 NZP=001, IR_NZP=011, LD_BEN -> BEN=1; IR_NZP=100 -> BEN=0; LD_BEN+LD_CC(0x8000) same cycle -> BEN from old NZP.
//  3 LD_PSR 16'h8301 -> Priv=1, Pri=3, NZP=001; Push Int_Pri=5 -> Priv=0, Pri=5, NZP=010; Pop -> o_PSR=16'h8301.
//  4 Five Pushes (DEPTH=4) -> Full after 4th; 5th changes nothing; o_Err=1 with macro, 0 without.
//  5 Pop when empty -> state unchanged, o_Err per macro; Push+Pop same cycle -> pop result only.
//  6 Assert i_RST with i_Push high and count=2 -> count=0, PSR=reset values; no push recorded.

Source files
------------

// File: rtl/lc3_pkg.sv
// +--------------------------------------------------------------------+
// | lc3_pkg : shared constants for the PSR unit                        |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package lc3_pkg;

  localparam int       PRI_LSB    = 8;
  localparam logic [2:0] NZP_RESET = 3'b010;
  localparam logic     PRIV_USER  = 1'b1;
  localparam logic     PRIV_SUPER = 1'b0;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;

endpackage

`default_nettype wire

// File: rtl/psr_lifo.sv
// +--------------------------------------------------------------------+
// | psr_lifo : shadow stack for saved PSR images (push/pop, flags)     |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module psr_lifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;
  logic [AW-1:0]    wr_idx, rd_idx;

  // Pop wins over push; either is ignored when it would over/underflow.
  assign pop_ok  = i_pop && !empty_q;
  assign push_ok = i_push && !i_pop && !full_q;
  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - CW'(1));

  always_comb begin
    count_d = count_q;
    if (pop_ok) begin
      count_d = count_q - CW'(1);
    end else if (push_ok) begin
      count_d = count_q + CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_idx] <= i_din;
    end
  end

  assign o_dout  = mem_q[rd_idx];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

`default_nettype wire

// File: rtl/psr_unit.sv
// +--------------------------------------------------------------------+
// | psr_unit : processor status register, BEN latch, PSR shadow stack  |
// | Option   : PSR_STACK_ERR_EN enables the sticky stack error flag    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module psr_unit
  import lc3_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PRI_W       = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_LD_CC,
  input  logic [DATA_W-1:0] i_Bus,
  input  logic              i_LD_PSR,
  input  logic              i_LD_BEN,
  input  logic [2:0]        i_IR_NZP,
  input  logic              i_Push,
  input  logic [PRI_W-1:0]  i_Int_Pri,
  input  logic              i_Pop,
  output logic [2:0]        o_NZP,
  output logic [DATA_W-1:0] o_PSR,
  output logic              o_Priv,
  output logic [PRI_W-1:0]  o_Pri,
  output logic              o_BEN,
  output logic              o_Stack_Empty,
  output logic              o_Stack_Full,
  output logic              o_Err
);

  localparam int SW = PRI_W + 4;

  logic             priv_q, priv_d;
  logic [PRI_W-1:0] pri_q, pri_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             ben_q, ben_d;
  logic [2:0]       cc;
  logic             stk_push, stk_pop;
  logic             stk_full, stk_empty;
  logic [SW-1:0]    stk_din, stk_dout;

  always_comb begin
    cc        = '0;
    cc[NZP_N] = i_Bus[DATA_W-1];
    cc[NZP_Z] = (i_Bus == '0);
    cc[NZP_P] = !i_Bus[DATA_W-1] && (i_Bus != '0);
  end

  assign stk_din = {priv_q, pri_q, nzp_q};

  // One PSR source per cycle: pop, then push, then full load, then CC.
  always_comb begin
    priv_d   = priv_q;
    pri_d    = pri_q;
    nzp_d    = nzp_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ben_d    = i_LD_BEN ? |(i_IR_NZP & nzp_q) : ben_q;
    if (i_Pop) begin
      if (!stk_empty) begin
        stk_pop                = 1'b1;
        {priv_d, pri_d, nzp_d} = stk_dout;
      end
    end else if (i_Push) begin
      if (!stk_full) begin
        stk_push = 1'b1;
        priv_d   = PRIV_SUPER;
        pri_d    = i_Int_Pri;
        nzp_d    = NZP_RESET;
      end
    end else if (i_LD_PSR) begin
      priv_d = i_Bus[DATA_W-1];
      pri_d  = i_Bus[PRI_LSB +: PRI_W];
      nzp_d  = i_Bus[2:0];
    end else if (i_LD_CC) begin
      nzp_d = cc;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      priv_q <= PRIV_SUPER;
      pri_q  <= '0;
      nzp_q  <= NZP_RESET;
      ben_q  <= 1'b0;
    end else begin
      priv_q <= priv_d;
      pri_q  <= pri_d;
      nzp_q  <= nzp_d;
      ben_q  <= ben_d;
    end
  end

  psr_lifo #(
    .WIDTH (SW),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk     (i_CLK),
    .rst     (i_RST),
    .i_push  (stk_push),
    .i_pop   (stk_pop),
    .i_din   (stk_din),
    .o_dout  (stk_dout),
    .o_full  (stk_full),
    .o_empty (stk_empty)
  );

`ifdef PSR_STACK_ERR_EN
  logic err_q, err_d;
  logic err_evt;

  // Overflow, underflow, or a push colliding with a pop.
  assign err_evt = (i_Pop && stk_empty) || (i_Push && i_Pop) ||
                   (i_Push && !i_Pop && stk_full);

  always_comb begin
    err_d = err_q | err_evt;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_Err = err_q;
`else
  assign o_Err = 1'b0;
`endif

  always_comb begin
    o_PSR                     = '0;
    o_PSR[DATA_W-1]           = priv_q;
    o_PSR[PRI_LSB +: PRI_W]   = pri_q;
    o_PSR[2:0]                = nzp_q;
  end

  assign o_NZP         = nzp_q;
  assign o_Priv        = priv_q;
  assign o_Pri         = pri_q;
  assign o_BEN         = ben_q;
  assign o_Stack_Empty = stk_empty;
  assign o_Stack_Full  = stk_full;

endmodule

`default_nettype wire
